// File: rtl/span_renderer_if.sv
// Vector-table fetch bus and video FIFO bus of the span renderer.
interface span_renderer_if #(
    parameter int XW    = 10,
    parameter int YW    = 10,
    parameter int COL_W = 16,
    parameter int VEC_W = 10
);
    logic [VEC_W-1:0] vec_idx;
    logic             vec_rd;
    logic [XW-1:0]    x0;
    logic [YW-1:0]    y0;
    logic [XW-1:0]    x1;
    logic [YW-1:0]    y1;
    logic [COL_W-1:0] col;
    logic             vec_last;
    logic             fifo_full;
    logic             fifo_write;
    logic [COL_W-1:0] fifo_data;
    logic             fifo_sof;
    logic             fifo_eol;

    modport master (
        output vec_idx, vec_rd, fifo_write, fifo_data, fifo_sof, fifo_eol,
        input  x0, y0, x1, y1, col, vec_last, fifo_full
    );

    modport slave (
        input  vec_idx, vec_rd, fifo_write, fifo_data, fifo_sof, fifo_eol,
        output x0, y0, x1, y1, col, vec_last, fifo_full
    );
endinterface

// File: rtl/span_renderer.sv
// Scanline span renderer: fills vector-table spans into one line buffer while
// the other line buffer streams to the video FIFO and is cleared behind the read.
module span_renderer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int XW    = 10,
    parameter int YW    = 10,
    parameter int COL_W = 16,
    parameter int VEC_W = 10,
    parameter logic [COL_W-1:0] BG_COLOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            frame_start,
    span_renderer_if.master bus,
    output logic            busy,
    output logic [YW-1:0]   scan_y
);
    localparam int            DEPTH    = 1 << XW;
    localparam logic [XW-1:0] X_LAST   = XW'(H_RES - 1);
    localparam logic [XW:0]   X_LAST_W = (XW+1)'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_RES - 1);

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_DRAW, S_WAIT, S_FLUSH} state_t;
    typedef enum logic [1:0] {PH_FETCH, PH_EVAL, PH_SPAN} phase_t;

    state_t state_reg, state_next;
    phase_t phase_reg, phase_next;

    logic [XW-1:0]    clr_addr_reg;
    logic             restart_reg;
    logic             draw_sel_reg;
    logic [XW-1:0]    draw_x_reg;
    logic [VEC_W-1:0] vec_idx_reg;
    logic [YW-1:0]    scan_y_reg;
    logic             busy_reg;
    logic             copy_run_reg;
    logic [XW-1:0]    copy_addr_reg;
    logic [YW-1:0]    copy_line_reg;
    logic             rd_valid_reg, rd_sof_reg, rd_eol_reg;
    logic             out_write_reg, out_sof_reg, out_eol_reg;
    logic [COL_W-1:0] out_data_reg;

    logic             abort, covers, copy_idle, out_free, copy_issue;
    logic             vec_rd, clr_we, draw_we, swap;
    logic [XW-1:0]    span_end;
    logic [COL_W-1:0] copy_q;

    assign abort      = frame_start && (state_reg inside {S_DRAW, S_WAIT, S_FLUSH});
    assign covers     = (bus.y0 <= scan_y_reg) && (scan_y_reg <= bus.y1) &&
                        (bus.x0 <= bus.x1) && ({1'b0, bus.x0} <= X_LAST_W);
    assign span_end   = (bus.x1 > X_LAST) ? X_LAST : bus.x1;
    assign copy_idle  = !copy_run_reg && !rd_valid_reg;
    // The output register can take a new pixel when empty or when its pixel leaves now.
    assign out_free   = !out_write_reg || !bus.fifo_full;
    assign copy_issue = copy_run_reg && out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_CLEAR;
            phase_reg <= PH_FETCH;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        case (state_reg)
            S_CLEAR: if (clr_addr_reg == X_LAST)
                         state_next = (restart_reg || frame_start) ? S_DRAW : S_IDLE;
            S_IDLE:  if (frame_start) state_next = S_DRAW;
            S_DRAW: begin
                case (phase_reg)
                    PH_FETCH: phase_next = PH_EVAL;
                    PH_EVAL: begin
                        if (covers)             phase_next = PH_SPAN;
                        else if (bus.vec_last)  state_next = S_WAIT;
                        else                    phase_next = PH_FETCH;
                    end
                    PH_SPAN: begin
                        if (draw_x_reg == span_end) begin
                            if (bus.vec_last) state_next = S_WAIT;
                            else              phase_next = PH_FETCH;
                        end
                    end
                    default: phase_next = PH_FETCH;
                endcase
            end
            S_WAIT:  if (copy_idle) state_next = (scan_y_reg == Y_LAST) ? S_FLUSH : S_DRAW;
            S_FLUSH: if (copy_idle && out_free) state_next = S_IDLE;
            default: state_next = S_CLEAR;
        endcase
        if (state_next != state_reg) phase_next = PH_FETCH;
        if (abort)                   state_next = S_CLEAR;
    end

    always_comb begin
        vec_rd  = (state_reg == S_DRAW) && (phase_reg == PH_FETCH);
        clr_we  = (state_reg == S_CLEAR);
        draw_we = (state_reg == S_DRAW) && (phase_reg == PH_SPAN);
        swap    = (state_reg == S_WAIT) && copy_idle && !abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_addr_reg  <= '0;
            restart_reg   <= 1'b0;
            draw_sel_reg  <= 1'b0;
            draw_x_reg    <= '0;
            vec_idx_reg   <= '0;
            scan_y_reg    <= '0;
            busy_reg      <= 1'b0;
            copy_run_reg  <= 1'b0;
            copy_addr_reg <= '0;
            copy_line_reg <= '0;
            rd_valid_reg  <= 1'b0;
            rd_sof_reg    <= 1'b0;
            rd_eol_reg    <= 1'b0;
            out_write_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sof_reg   <= 1'b0;
            out_eol_reg   <= 1'b0;
        end else begin
            clr_addr_reg <= (state_reg == S_CLEAR && state_next == S_CLEAR) ?
                            clr_addr_reg + 1'b1 : '0;

            if (abort)
                restart_reg <= 1'b1;
            else if (state_reg == S_CLEAR)
                restart_reg <= (state_next == S_CLEAR) ? (restart_reg || frame_start) : 1'b0;

            if (frame_start)
                busy_reg <= 1'b1;
            else if (state_reg == S_FLUSH && state_next == S_IDLE)
                busy_reg <= 1'b0;

            if (state_reg inside {S_CLEAR, S_IDLE} && state_next == S_DRAW)
                scan_y_reg <= '0;
            else if (state_reg == S_WAIT && state_next == S_DRAW)
                scan_y_reg <= scan_y_reg + 1'b1;

            if (state_reg != S_DRAW && state_next == S_DRAW)
                vec_idx_reg <= '0;
            else if (state_reg == S_DRAW && state_next == S_DRAW &&
                     phase_reg != PH_FETCH && phase_next == PH_FETCH)
                vec_idx_reg <= vec_idx_reg + 1'b1;

            if (state_reg == S_DRAW && phase_reg == PH_EVAL)
                draw_x_reg <= bus.x0;
            else if (draw_we)
                draw_x_reg <= draw_x_reg + 1'b1;

            if (swap) draw_sel_reg <= ~draw_sel_reg;

            if (abort) begin
                copy_run_reg  <= 1'b0;
                rd_valid_reg  <= 1'b0;
                out_write_reg <= 1'b0;
                out_sof_reg   <= 1'b0;
                out_eol_reg   <= 1'b0;
            end else begin
                if (swap) begin
                    copy_run_reg  <= 1'b1;
                    copy_addr_reg <= '0;
                    copy_line_reg <= scan_y_reg;
                end else if (copy_issue) begin
                    if (copy_addr_reg == X_LAST) copy_run_reg <= 1'b0;
                    copy_addr_reg <= copy_addr_reg + 1'b1;
                end
                if (copy_issue) begin
                    rd_sof_reg <= (copy_addr_reg == '0) && (copy_line_reg == '0);
                    rd_eol_reg <= (copy_addr_reg == X_LAST);
                end
                // Read data waits in the RAM output register while the FIFO stalls.
                rd_valid_reg <= copy_issue || (rd_valid_reg && !out_free);
                if (out_free) begin
                    out_write_reg <= rd_valid_reg;
                    out_sof_reg   <= rd_valid_reg && rd_sof_reg;
                    out_eol_reg   <= rd_valid_reg && rd_eol_reg;
                    if (rd_valid_reg) out_data_reg <= copy_q;
                end
            end
        end
    end

    // Two line buffers; the one not being drawn is the copy buffer (read-first, cleared on read).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            logic [COL_W-1:0] mem [DEPTH];
            logic [COL_W-1:0] rd_q;
            logic             is_draw, re, we;
            logic [XW-1:0]    addr;
            logic [COL_W-1:0] wdata;

            always_comb begin
                is_draw = (draw_sel_reg == 1'(gi));
                re      = copy_issue && !is_draw;
                we      = clr_we || (draw_we && is_draw) || re;
                addr    = clr_we ? clr_addr_reg : (is_draw ? draw_x_reg : copy_addr_reg);
                wdata   = (draw_we && is_draw && !clr_we) ? bus.col : BG_COLOR;
            end

            always_ff @(posedge clk) begin
                if (re) rd_q <= mem[addr];
                if (we) mem[addr] <= wdata;
            end
        end
    endgenerate

    assign copy_q = draw_sel_reg ? g_buf[0].rd_q : g_buf[1].rd_q;

    assign bus.vec_idx    = vec_idx_reg;
    assign bus.vec_rd     = vec_rd;
    assign bus.fifo_write = out_write_reg;
    assign bus.fifo_data  = out_data_reg;
    assign bus.fifo_sof   = out_sof_reg;
    assign bus.fifo_eol   = out_eol_reg;
    assign busy           = busy_reg;
    assign scan_y         = scan_y_reg;
endmodule

// File: tb/tb_span_renderer.sv
// Directed bench for span_renderer on a 16x8 frame: probe table, whole-frame model
// compare, FIFO backpressure, abort-on-retrigger and asynchronous reset recovery.
module tb_span_renderer;
    localparam int H = 16;
    localparam int V = 8;
    localparam int NPIX = H * V;
    localparam logic [15:0] BG = 16'h0055;

    typedef struct { int x0; int y0; int x1; int y1; logic [15:0] col; bit last; } vec_t;
    typedef struct { int scen; bit rnd; int y; int x; logic [15:0] exp; } probe_t;
    typedef struct packed { logic [15:0] d; logic sof; logic eol; } pix_t;

    logic clk, rst_n, frame_start, busy;
    logic [3:0] scan_y;
    span_renderer_if #(.XW(6), .YW(4), .COL_W(16), .VEC_W(4)) bus ();

    span_renderer #(.H_RES(H), .V_RES(V), .XW(6), .YW(4), .COL_W(16), .VEC_W(4),
                    .BG_COLOR(BG)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .bus(bus.master), .busy(busy), .scan_y(scan_y)
    );

    vec_t        tbl [16];
    pix_t        cap_q [$];
    logic [15:0] got_px [NPIX];
    int          n_checks = 0, n_errors = 0, stab_err = 0;
    bit          rand_full = 0;
    bit          prev_stall = 0;
    pix_t        prev_pix;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Vector table: registered read, holds the entry while vec_rd=0.
    initial begin
        bit rd;
        int idx;
        bus.x0 = 0; bus.y0 = 0; bus.x1 = 0; bus.y1 = 0; bus.col = 0; bus.vec_last = 0;
        forever begin
            @(negedge clk);
            rd  = bus.vec_rd;
            idx = int'(bus.vec_idx);
            @(posedge clk);
            #1;
            if (rd) begin
                bus.x0 = 6'(tbl[idx].x0); bus.y0 = 4'(tbl[idx].y0);
                bus.x1 = 6'(tbl[idx].x1); bus.y1 = 4'(tbl[idx].y1);
                bus.col = tbl[idx].col;   bus.vec_last = tbl[idx].last;
            end
        end
    end

    initial begin
        bus.fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.fifo_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // FIFO sink: captures transfers and checks hold-while-full.
    always @(negedge clk) begin
        if (prev_stall && !(bus.fifo_write && bus.fifo_data == prev_pix.d &&
                            bus.fifo_sof == prev_pix.sof && bus.fifo_eol == prev_pix.eol))
            stab_err++;
        prev_stall = rst_n && bus.fifo_write && bus.fifo_full;
        prev_pix   = '{d: bus.fifo_data, sof: bus.fifo_sof, eol: bus.fifo_eol};
        if (rst_n && bus.fifo_write && !bus.fifo_full) cap_q.push_back(prev_pix);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            $display("check %s: %0h ok", name, got);
        end
    endtask

    task automatic load_scen(input int s);
        for (int i = 0; i < 16; i++) tbl[i] = '{0, 15, 0, 0, 16'h0000, 1'b1};
        case (s)
            0: tbl[0] = '{0, 0, 15, 7, 16'hFFFF, 1'b1};
            1: begin
                tbl[0] = '{3, 5, 6, 5, 16'h1111, 1'b0};
                tbl[1] = '{5, 5, 9, 5, 16'h2222, 1'b1};
            end
            2: begin
                tbl[0] = '{12, 0, 30, 0, 16'h3333, 1'b0};
                tbl[1] = '{18, 0, 25, 0, 16'h4444, 1'b1};
            end
            default: begin
                tbl[0] = '{8, 2, 3, 2, 16'h5555, 1'b0};
                tbl[1] = '{2, 1, 4, 3, 16'h7777, 1'b0};
                tbl[2] = '{3, 2, 3, 2, 16'h0AAA, 1'b1};
            end
        endcase
    endtask

    function automatic logic [15:0] model_px(input int y, input int x);
        logic [15:0] p = BG;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].y0 <= y && y <= tbl[i].y1 && tbl[i].x0 <= tbl[i].x1 &&
                x >= tbl[i].x0 && x <= tbl[i].x1)
                p = tbl[i].col;
            if (tbl[i].last) break;
        end
        return p;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    // Collects one frame and checks it against the model.
    task automatic do_frame(input string name, input bit pulse);
        int cyc, mk_err, px_err;
        cap_q.delete();
        stab_err = 0;
        if (pulse) pulse_start();
        cyc = 0;
        while (cap_q.size() < NPIX / 2 && cyc < 4000) begin @(posedge clk); cyc++; end
        #1 chk({name, "_busy_mid"}, 32'(busy), 32'd1);
        while (cap_q.size() < NPIX && cyc < 8000) begin @(posedge clk); cyc++; end
        cyc = 0;
        while (busy && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk({name, "_busy_end"}, 32'(busy), 32'd0);
        repeat (8) @(posedge clk);
        chk({name, "_count"}, 32'(cap_q.size()), 32'(NPIX));
        mk_err = 0;
        px_err = 0;
        for (int k = 0; k < NPIX; k++) begin
            if (k < cap_q.size()) begin
                got_px[k] = cap_q[k].d;
                if (cap_q[k].sof != (k == 0) || cap_q[k].eol != (k % H == H - 1)) mk_err++;
                if (cap_q[k].d !== model_px(k / H, k % H)) px_err++;
            end else begin
                got_px[k] = 16'hDEAD;
                px_err++;
            end
        end
        chk({name, "_markers"}, 32'(mk_err), 32'd0);
        chk({name, "_pixels"}, 32'(px_err), 32'd0);
        chk({name, "_stable"}, 32'(stab_err), 32'd0);
        $display("frame %s: %0d pixels captured", name, cap_q.size());
    endtask

    initial begin
        probe_t probes[$];
        int cur_s, found, cyc;
        bit cur_r;

        rst_n = 1'b0;
        frame_start = 1'b0;
        load_scen(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_write", 32'(bus.fifo_write), 32'd0);
        chk("rst_fifo_data", 32'(bus.fifo_data), 32'd0);
        chk("rst_sof_eol", {30'd0, bus.fifo_sof, bus.fifo_eol}, 32'd0);
        chk("rst_vec_rd", 32'(bus.vec_rd), 32'd0);
        chk("rst_vec_idx", 32'(bus.vec_idx), 32'd0);
        chk("rst_scan_y", 32'(scan_y), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (H + 10) @(posedge clk);
        #1 chk("idle_quiet", 32'(cap_q.size()), 32'd0);

        probes.push_back('{0, 0, 0, 0, 16'hFFFF});
        probes.push_back('{0, 0, 7, 15, 16'hFFFF});
        probes.push_back('{0, 0, 3, 8, 16'hFFFF});
        probes.push_back('{1, 0, 5, 2, BG});
        probes.push_back('{1, 0, 5, 3, 16'h1111});
        probes.push_back('{1, 0, 5, 4, 16'h1111});
        probes.push_back('{1, 0, 5, 5, 16'h2222});
        probes.push_back('{1, 0, 5, 9, 16'h2222});
        probes.push_back('{1, 0, 5, 10, BG});
        probes.push_back('{1, 0, 6, 5, BG});
        probes.push_back('{1, 0, 7, 5, BG});
        probes.push_back('{1, 0, 4, 5, BG});
        probes.push_back('{2, 0, 0, 11, BG});
        probes.push_back('{2, 0, 0, 12, 16'h3333});
        probes.push_back('{2, 0, 0, 15, 16'h3333});
        probes.push_back('{2, 0, 0, 2, BG});
        probes.push_back('{2, 0, 1, 12, BG});
        probes.push_back('{3, 0, 1, 2, 16'h7777});
        probes.push_back('{3, 0, 2, 3, 16'h0AAA});
        probes.push_back('{3, 0, 2, 4, 16'h7777});
        probes.push_back('{3, 0, 2, 8, BG});
        probes.push_back('{3, 0, 3, 4, 16'h7777});
        probes.push_back('{3, 0, 4, 3, BG});
        probes.push_back('{1, 1, 5, 4, 16'h1111});
        probes.push_back('{1, 1, 5, 9, 16'h2222});
        probes.push_back('{1, 1, 6, 5, BG});
        probes.push_back('{3, 1, 2, 3, 16'h0AAA});

        cur_s = -1;
        cur_r = 0;
        foreach (probes[i]) begin
            if (probes[i].scen != cur_s || probes[i].rnd != cur_r) begin
                cur_s = probes[i].scen;
                cur_r = probes[i].rnd;
                load_scen(cur_s);
                repeat (5) @(posedge clk);
                rand_full = cur_r;
                do_frame($sformatf("s%0d_r%0d", cur_s, cur_r), 1'b1);
                rand_full = 0;
            end
            chk($sformatf("probe_s%0d_r%0d_y%0d_x%0d", probes[i].scen, probes[i].rnd,
                          probes[i].y, probes[i].x),
                32'(got_px[probes[i].y * H + probes[i].x]), 32'(probes[i].exp));
        end

        // Retrigger in the middle of line 3's readout.
        load_scen(1);
        repeat (5) @(posedge clk);
        cap_q.delete();
        pulse_start();
        cyc = 0;
        while (cap_q.size() < 3 * H + 6 && cyc < 4000) begin @(posedge clk); cyc++; end
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        cap_q.delete();
        @(negedge clk);
        chk("abort_drop_write", 32'(bus.fifo_write), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        do_frame("abort_restart", 1'b0);

        // Asynchronous reset while line 3 is being drawn.
        load_scen(3);
        repeat (5) @(posedge clk);
        cap_q.delete();
        pulse_start();
        found = 0;
        cyc = 0;
        while (!found && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (scan_y == 4'd3 && busy) found = 1;
        end
        chk("reach_line3", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_fifo_write", 32'(bus.fifo_write), 32'd0);
        chk("arst_fifo_data", 32'(bus.fifo_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_scan_y", 32'(scan_y), 32'd0);
        chk("arst_vec_rd", 32'(bus.vec_rd), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        cap_q.delete();
        pulse_start();
        do_frame("arst_recover", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
